// File: rtl/example_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ valid/data requesters share one registered
// valid/ready output channel with rotating priority and a wrapping grant count.
package example_pkg;
    localparam int EXAMPLE_TYPE_LEN = 5;
    typedef logic [EXAMPLE_TYPE_LEN-1:0] example_type_t;
    typedef struct packed {
        logic          valid;
        example_type_t data;
    } example_struct_s;
endpackage

module example_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = example_pkg::EXAMPLE_TYPE_LEN,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [DATA_W:0]                o_out,
    output logic [SRC_W-1:0]               o_out_src,
    input  logic                           i_out_ready,
    output logic [7:0]                     o_grant_cnt
);
    localparam int CW = SRC_W + 1;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SRC_W-1:0]  out_src;
    logic [SRC_W-1:0]  ptr;
    logic [7:0]        grant_cnt;

    logic              can_load;
    logic              found;
    logic              accept;
    logic [SRC_W-1:0]  win;
    logic [CW-1:0]     idx;

    // o_out packs as example_struct_s: valid in the MSB, payload below it.
    assign o_out       = {out_valid, out_data};
    assign o_out_src   = out_src;
    assign o_grant_cnt = grant_cnt;

    assign can_load = !out_valid || i_out_ready;
    assign accept   = can_load && found;

    // Scan from ptr upward with wrap; the first valid requester wins.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + CW'(i);
            if (idx >= CW'(NUM_REQ))
                idx = idx - CW'(NUM_REQ);
            if (!found && i_req_valid[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SRC_W-1:0];
            end
        end
    end

    // Ready is gated by reset so no requester sees an accept while held in reset.
    always_comb begin
        o_req_ready = '0;
        if (!i_rst && accept)
            o_req_ready[win] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
        end else if (can_load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= i_req_data[win];
                out_src   <= win;
                ptr       <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                grant_cnt <= grant_cnt + 8'd1;
            end else begin
                // Consumed (or already empty) with nothing to load: drain.
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_example_rr_arbiter.sv
// Randomized and directed bench for example_rr_arbiter with a queue scoreboard
// fed by a distance-based round-robin model, plus a 3-requester instance.
module tb_example_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 5;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic [DW:0]          out;
    logic [SW-1:0]        out_src;
    logic                 out_ready;
    logic [7:0]           grant_cnt;

    example_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_out(out), .o_out_src(out_src),
        .i_out_ready(out_ready), .o_grant_cnt(grant_cnt)
    );

    // Non-power-of-two instance, all requesters permanently valid.
    logic                 rst3;
    logic [2:0]           req_valid3;
    logic [2:0][DW-1:0]   req_data3;
    logic [2:0]           req_ready3;
    logic [DW:0]          out3;
    logic [1:0]           out_src3;
    logic [7:0]           grant_cnt3;

    example_rr_arbiter #(.NUM_REQ(3), .DATA_W(DW)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_req_valid(req_valid3), .i_req_data(req_data3),
        .o_req_ready(req_ready3), .o_out(out3), .o_out_src(out_src3),
        .i_out_ready(1'b1), .o_grant_cnt(grant_cnt3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int m_ptr;
    bit m_valid;
    int m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, predict at mid-cycle.
    task automatic step(input logic [N-1:0] v, input logic rdy);
        int win;
        int best;
        bit can_load;
        logic [31:0] exp_ready;
        req_valid = v;
        out_ready = rdy;
        @(negedge clk);
        win  = -1;
        best = N;
        for (int k = 0; k < N; k++) begin
            if (v[k] && ((k - m_ptr + N) % N) < best) begin
                best = (k - m_ptr + N) % N;
                win  = k;
            end
        end
        can_load  = !m_valid || rdy;
        exp_ready = (can_load && win >= 0) ? (32'd1 << win) : 32'd0;
        check("req_ready", 32'(req_ready), exp_ready);
        check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        check("out_valid", 32'(out[DW]), 32'(m_valid));
        if (can_load) begin
            if (win >= 0) begin
                q.push_back('{src: 32'(win), data: 32'(req_data[win])});
                m_ptr   = (win + 1) % N;
                m_cnt   = (m_cnt + 1) % 256;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, with every requester valid.
    task automatic do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out[DW]), 32'd0);
        check("rst_out_data", 32'(out[DW-1:0]), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: whenever the output is valid it must match the oldest expected
    // entry; the entry retires only when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out[DW]) begin
                if (q.size() == 0) begin
                    check("out_unexpected", 32'd1, 32'd0);
                end else begin
                    check("out_src", 32'(out_src), q[0].src);
                    check("out_data", 32'(out[DW-1:0]), q[0].data);
                    if (out_ready)
                        q.pop_front();
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        rst3       = 1'b1;
        req_valid  = '1;
        req_data   = '0;
        out_ready  = 1'b1;
        req_valid3 = 3'b111;
        for (int k = 0; k < 3; k++)
            req_data3[k] = DW'(k + 9);

        // Three-requester rotation straight out of reset.
        repeat (2) @(posedge clk);
        #1 rst3 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("n3_ready", 32'(req_ready3), 32'd1 << (i % 3));
            if (i > 0) begin
                check("n3_src", 32'(out_src3), 32'((i - 1) % 3));
                check("n3_data", 32'(out3[DW-1:0]), 32'((i - 1) % 3 + 9));
            end
        end
        @(posedge clk);
        #1;

        do_reset();

        // Full contention: strict rotation, one transfer per cycle.
        for (int k = 0; k < N; k++)
            req_data[k] = DW'(k + 1);
        repeat (8) step('1, 1'b1);
        check("cnt_after_8", 32'(grant_cnt), 32'd8);

        // Backpressure: src 2 / 0x15 held for 5 stalled cycles, then no bubble.
        req_data[2] = 5'h15;
        step(4'b0100, 1'b1);
        repeat (5) step('1, 1'b0);
        repeat (4) step('1, 1'b1);

        // Sparse requests with ptr at 2.
        do_reset();
        step(4'b0010, 1'b1);
        repeat (4) step(4'b1010, 1'b1);

        // 256 accepts wrap the counter, then drain.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < N; k++)
                req_data[k] = DW'($urandom);
            step('1, 1'b1);
        end
        check("cnt_wrap", 32'(grant_cnt), 32'd0);
        step('0, 1'b1);
        check("drain_valid", 32'(out[DW]), 32'd0);
        step('0, 1'b1);

        // Random traffic, with a reset landing while the output is stalled.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++)
                req_data[k] = DW'($urandom);
            if (i == 200) begin
                step('1, 1'b0);
                do_reset();
                step('1, 1'b1);
            end else begin
                step(N'($urandom), $urandom_range(0, 3) != 0);
            end
        end
        step('0, 1'b1);
        step('0, 1'b1);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
